// File: rtl/regfile_8x16_sb_pkg.sv
// rf_pkg: shared sizing and types for the 8x16 register bank.
//   DATA_W     - register width
//   NREGS      - number of architectural registers (R0 hardwired to zero)
//   ADDR_W     - register address width
//   reg_addr_t - register index type
//   reg_data_t - register word type
//   wr_hit()   - true when the write-back port targets a given register
package rf_pkg;

    localparam int DATA_W = 16;
    localparam int NREGS  = 8;
    localparam int ADDR_W = $clog2(NREGS);

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    function automatic logic wr_hit(input logic      we,
                                    input reg_addr_t wa,
                                    input reg_addr_t a);
        return we && (wa == a);
    endfunction

endpackage

// File: rtl/regfile_8x16_sb_if.sv
// regfile_8x16_sb_if: decode / write-back bus of the register bank.
//   master - driven by the core: read addresses, write-back, issue request
//   slave  - the register bank: read data, busy flags, stall
interface regfile_8x16_sb_if;
    import rf_pkg::*;

    reg_addr_t ra_addr;
    reg_data_t ra_data;
    logic      ra_busy;
    reg_addr_t rb_addr;
    reg_data_t rb_data;
    logic      rb_busy;
    logic      wr_en;
    reg_addr_t wr_addr;
    reg_data_t wr_data;
    logic      issue_en;
    reg_addr_t issue_rd;
    logic      stall;

    modport master (
        output ra_addr, rb_addr, wr_en, wr_addr, wr_data, issue_en, issue_rd,
        input  ra_data, ra_busy, rb_data, rb_busy, stall
    );

    modport slave (
        input  ra_addr, rb_addr, wr_en, wr_addr, wr_data, issue_en, issue_rd,
        output ra_data, ra_busy, rb_data, rb_busy, stall
    );

endinterface

// File: rtl/regfile_8x16_sb_reg_word16.sv
// reg_word16: one write-enabled DATA_W-bit register, async active-high reset to 0.
//   clk - clock
//   rst - asynchronous active-high reset
//   we  - write enable
//   d   - write value
//   q   - stored value
module reg_word16
    import rf_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      we,
    input  reg_data_t d,
    output reg_data_t q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (we) begin
            q <= d;
        end
    end

endmodule

// File: rtl/regfile_8x16_sb.sv
// regfile_8x16_sb: 8x16 register bank with two combinational read ports,
// one write port, write-to-read bypass and a pending-write scoreboard.
//   clk - clock
//   rst - asynchronous active-high reset
//   bus - decode/write-back bus (slave side): read ports with busy flags,
//         write-back port, destination issue with stall
module regfile_8x16_sb
    import rf_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    regfile_8x16_sb_if.slave bus
);

    reg_data_t        regs [NREGS];
    logic [NREGS-1:1] pending;
    logic [NREGS-1:1] pending_nxt;
    logic [NREGS-1:0] pend_full;
    logic             ra_hit;
    logic             rb_hit;
    logic             rd_hit;

    // R0 has no storage; a constant zero keeps the read mux uniform.
    assign regs[0] = '0;

    genvar g;
    for (g = 1; g < NREGS; g++) begin : g_word
        reg_word16 u_word (
            .clk (clk),
            .rst (rst),
            .we  (wr_hit(bus.wr_en, bus.wr_addr, reg_addr_t'(g))),
            .d   (bus.wr_data),
            .q   (regs[g])
        );
    end

    // Bit 0 is tied low so R0 is never busy without a special case.
    assign pend_full = {pending, 1'b0};

    assign ra_hit = wr_hit(bus.wr_en, bus.wr_addr, bus.ra_addr);
    assign rb_hit = wr_hit(bus.wr_en, bus.wr_addr, bus.rb_addr);
    assign rd_hit = wr_hit(bus.wr_en, bus.wr_addr, bus.issue_rd);

    assign bus.ra_data = (bus.ra_addr == '0) ? '0 :
                         ra_hit              ? bus.wr_data : regs[bus.ra_addr];
    assign bus.rb_data = (bus.rb_addr == '0) ? '0 :
                         rb_hit              ? bus.wr_data : regs[bus.rb_addr];

    // An arriving write-back resolves the hazard in the same cycle.
    assign bus.ra_busy = pend_full[bus.ra_addr] & ~ra_hit;
    assign bus.rb_busy = pend_full[bus.rb_addr] & ~rb_hit;

    // Refuse issue on operand hazards or an outstanding write to the same destination.
    assign bus.stall = bus.issue_en &
                       (bus.ra_busy | bus.rb_busy | (pend_full[bus.issue_rd] & ~rd_hit));

    // Release is applied first so a same-edge reservation of that register wins.
    always_comb begin
        pending_nxt = pending;
        for (int i = 1; i < NREGS; i++) begin
            if (wr_hit(bus.wr_en, bus.wr_addr, reg_addr_t'(i))) begin
                pending_nxt[i] = 1'b0;
            end
            if (bus.issue_en && !bus.stall && (bus.issue_rd == reg_addr_t'(i))) begin
                pending_nxt[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

endmodule

// File: tb/tb_regfile_8x16_sb.sv
// tb_regfile_8x16_sb: scoreboard bench for regfile_8x16_sb.
// Expected outputs are queued when inputs are applied and compared before the next edge.
module tb_regfile_8x16_sb;
    import rf_pkg::*;

    localparam int SEL_RA_DATA = 0;
    localparam int SEL_RB_DATA = 1;
    localparam int SEL_RA_BUSY = 2;
    localparam int SEL_RB_BUSY = 3;
    localparam int SEL_STALL   = 4;

    typedef struct {
        string       tag;
        int          sel;
        logic [15:0] exp;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t sb[$];

    logic [15:0] m_regs [8];
    logic [7:0]  m_pend;

    regfile_8x16_sb_if bus ();

    regfile_8x16_sb dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] actual(input int sel);
        case (sel)
            SEL_RA_DATA: return bus.ra_data;
            SEL_RB_DATA: return bus.rb_data;
            SEL_RA_BUSY: return {15'd0, bus.ra_busy};
            SEL_RB_BUSY: return {15'd0, bus.rb_busy};
            default:     return {15'd0, bus.stall};
        endcase
    endfunction

    // ---- reference model of the register bank ----
    function automatic logic m_hit(input logic [2:0] a);
        return bus.wr_en && (bus.wr_addr == a);
    endfunction

    function automatic logic [15:0] m_data(input logic [2:0] a);
        if (a == 3'd0) return 16'h0000;
        if (m_hit(a))  return bus.wr_data;
        return m_regs[a];
    endfunction

    function automatic logic m_busy(input logic [2:0] a);
        if (a == 3'd0) return 1'b0;
        return m_pend[a] && !m_hit(a);
    endfunction

    function automatic logic m_stall();
        if (!bus.issue_en) return 1'b0;
        return m_busy(bus.ra_addr) || m_busy(bus.rb_addr) || m_busy(bus.issue_rd);
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
        m_pend = 8'h00;
    endtask

    task automatic m_edge();
        logic s;
        if (rst) begin
            m_clear();
        end else begin
            s = m_stall();
            if (bus.wr_en && bus.wr_addr != 3'd0) begin
                m_regs[bus.wr_addr] = bus.wr_data;
                m_pend[bus.wr_addr] = 1'b0;
            end
            if (bus.issue_en && !s && bus.issue_rd != 3'd0) m_pend[bus.issue_rd] = 1'b1;
        end
    endtask

    task automatic push(input string tag, input int sel, input logic [15:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic push_model();
        push("m_ra_data", SEL_RA_DATA, m_data(bus.ra_addr));
        push("m_rb_data", SEL_RB_DATA, m_data(bus.rb_addr));
        push("m_ra_busy", SEL_RA_BUSY, {15'd0, m_busy(bus.ra_addr)});
        push("m_rb_busy", SEL_RB_BUSY, {15'd0, m_busy(bus.rb_addr)});
        push("m_stall",   SEL_STALL,   {15'd0, m_stall()});
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, actual(e.sel), e.exp);
        end
    endtask

    // Apply inputs just after a rising edge and queue the model's expectations.
    task automatic drive(input logic [2:0] ra, input logic [2:0] rb,
                         input logic we, input logic [2:0] wa, input logic [15:0] wd,
                         input logic ie, input logic [2:0] ird);
        bus.ra_addr  = ra;
        bus.rb_addr  = rb;
        bus.wr_en    = we;
        bus.wr_addr  = wa;
        bus.wr_data  = wd;
        bus.issue_en = ie;
        bus.issue_rd = ird;
        #1;
        push_model();
    endtask

    // Compare on the falling edge, then advance the model across the rising edge.
    task automatic cycle();
        @(negedge clk);
        drain();
        @(posedge clk);
        m_edge();
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_clear();
        rst = 1'b1;

        // Reset state
        drive(3'd3, 3'd5, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
        push("rst_ra_data", SEL_RA_DATA, 16'h0000);
        push("rst_ra_busy", SEL_RA_BUSY, 16'h0000);
        push("rst_stall",   SEL_STALL,   16'h0000);
        cycle();
        rst = 1'b0;

        // Load R3 and reserve it in the same edge, then reset mid-cycle
        drive(3'd0, 3'd0, 1'b1, 3'd3, 16'h1234, 1'b1, 3'd3);
        cycle();
        drive(3'd3, 3'd0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
        push("r3_loaded", SEL_RA_DATA, 16'h1234);
        push("r3_busy",   SEL_RA_BUSY, 16'h0001);
        drain();
        rst = 1'b1;
        #1;
        m_clear();
        push("midrst_data", SEL_RA_DATA, 16'h0000);
        push("midrst_busy", SEL_RA_BUSY, 16'h0000);
        push_model();
        cycle();
        // Write during reset is ignored
        drive(3'd3, 3'd0, 1'b1, 3'd3, 16'h5555, 1'b0, 3'd0);
        cycle();
        rst = 1'b0;
        drive(3'd3, 3'd0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
        push("rst_wr_ignored", SEL_RA_DATA, 16'h0000);
        cycle();

        // Write R5, read it next cycle
        drive(3'd0, 3'd0, 1'b1, 3'd5, 16'hBEEF, 1'b0, 3'd0);
        cycle();
        drive(3'd5, 3'd0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
        push("r5_data", SEL_RA_DATA, 16'hBEEF);
        push("r5_busy", SEL_RA_BUSY, 16'h0000);
        cycle();

        // R0: write discarded, bypass suppressed, issue never reserves
        drive(3'd0, 3'd0, 1'b1, 3'd0, 16'hFFFF, 1'b1, 3'd0);
        push("r0_bypass", SEL_RA_DATA, 16'h0000);
        push("r0_stall",  SEL_STALL,   16'h0000);
        cycle();
        drive(3'd0, 3'd0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd0);
        push("r0_data", SEL_RA_DATA, 16'h0000);
        push("r0_busy", SEL_RA_BUSY, 16'h0000);
        push("r0_reiss", SEL_STALL,  16'h0000);
        cycle();

        // Same-cycle bypass on both ports
        drive(3'd2, 3'd2, 1'b1, 3'd2, 16'hA5A5, 1'b0, 3'd0);
        push("byp_ra", SEL_RA_DATA, 16'hA5A5);
        push("byp_rb", SEL_RB_DATA, 16'hA5A5);
        cycle();

        // Reserve R4, operand hazard, release by write-back
        drive(3'd0, 3'd0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd4);
        push("iss4_stall", SEL_STALL, 16'h0000);
        cycle();
        drive(3'd4, 3'd0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd1);
        push("r4_busy",  SEL_RA_BUSY, 16'h0001);
        push("r4_stall", SEL_STALL,   16'h0001);
        cycle();
        drive(3'd4, 3'd0, 1'b1, 3'd4, 16'h0042, 1'b1, 3'd1);
        push("r4_wb_busy",  SEL_RA_BUSY, 16'h0000);
        push("r4_wb_stall", SEL_STALL,   16'h0000);
        push("r4_wb_data",  SEL_RA_DATA, 16'h0042);
        cycle();
        drive(3'd4, 3'd1, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
        push("r4_released", SEL_RA_BUSY, 16'h0000);
        push("r1_reserved", SEL_RB_BUSY, 16'h0001);
        cycle();
        drive(3'd0, 3'd0, 1'b1, 3'd1, 16'h0011, 1'b0, 3'd0);
        cycle();

        // Simultaneous release and reservation of R6
        drive(3'd0, 3'd0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd6);
        cycle();
        drive(3'd0, 3'd0, 1'b1, 3'd6, 16'h0007, 1'b1, 3'd6);
        push("r6_setclr_stall", SEL_STALL, 16'h0000);
        cycle();
        drive(3'd6, 3'd0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd6);
        push("r6_data",  SEL_RA_DATA, 16'h0007);
        push("r6_busy",  SEL_RA_BUSY, 16'h0001);
        push("r6_waw",   SEL_STALL,   16'h0001);
        cycle();
        drive(3'd0, 3'd0, 1'b1, 3'd6, 16'h0008, 1'b0, 3'd0);
        cycle();

        // Random traffic against the model
        for (int n = 0; n < 300; n++) begin
            drive(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  16'($urandom),
                  1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_8x16_sb.md
# regfile_8x16_sb

Eight-entry, 16-bit general-purpose register bank for the single-cycle RISC core, with two combinational read ports, one write port, write-to-read bypass and a per-register pending-write scoreboard. It sits between decode (read addresses, destination issue) and write-back (result, write enable), and each of its words is a 16-bit write-enabled register. The scoreboard lets multi-cycle producers such as loads reserve a destination; decode stalls on operands that are not ready.

## Interface
Parameters:
- DATA_W, 16, register width
- NREGS, 8, number of registers; R0 is hardwired to zero
- ADDR_W, 3, register address width, equal to clog2(NREGS)

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  reset, asynchronous, active-high
- ra_addr  in  ADDR_W  read port A address
- ra_data  out  DATA_W  read port A data
- ra_busy  out  1  port A operand not yet available
- rb_addr  in  ADDR_W  read port B address
- rb_data  out  DATA_W  read port B data
- rb_busy  out  1  port B operand not yet available
- wr_en  in  1  write-back strobe
- wr_addr  in  ADDR_W  write-back destination
- wr_data  in  DATA_W  write-back value
- issue_en  in  1  decode requests a reservation of issue_rd
- issue_rd  in  ADDR_W  destination to reserve
- stall  out  1  issue refused this cycle

## Operation
- Storage:
  - regs[1..7] are DATA_W-bit registers.
  - regs[0] reads as 0, and writes to address 0 are discarded.
- Write: on a clk edge with wr_en=1 and wr_addr≠0, regs[wr_addr] ← wr_data.
- Read (combinational):
  - x_data = 0 when x_addr=0.
  - Otherwise x_data = wr_data when wr_en=1 and wr_addr=x_addr (bypass).
  - Otherwise x_data = regs[x_addr].
- Scoreboard: a pending[NREGS-1:1] vector.
  - x_busy = pending[x_addr] & ~(wr_en & wr_addr==x_addr). An arriving write resolves the busy bit in the same cycle.
  - x_busy is 0 for address 0.
- stall = issue_en & (ra_busy | rb_busy | (pending[issue_rd] & ~(wr_en & wr_addr==issue_rd))). This is WAW protection.
- Reservation: on an edge with issue_en=1, stall=0 and issue_rd≠0, pending[issue_rd] ← 1.
- Release: on an edge with wr_en=1 and wr_addr≠0, pending[wr_addr] ← 0.
- Simultaneous reservation and release of the same register: the reservation wins, so the bit stays 1. The data write still occurs.
- A write to a register that is not pending is legal (single-cycle ALU path). It writes and leaves pending at 0.

## Timing
- Reset: while rst=1, asynchronously:
  - all regs are 0 and all pending bits are 0;
  - ra_data/rb_data = 0 (or the bypass value if wr_en is active);
  - ra_busy=rb_busy=0, and stall=0 unless busy via write bypass (impossible after reset).
- Reset asserted mid-operation clears all reservations immediately. Writes arriving during reset are ignored.
- Read latency: 0 cycles, combinational from address and write inputs.
- Write-to-read: visible in the same cycle via bypass, and from storage from the next cycle.
- Reservation is visible as busy from the cycle after the issue edge.
- No combinational path from stall back into the write logic.

## Structure
- Shared package rf_pkg holds DATA_W, NREGS, ADDR_W and the typedef reg_addr_t.
- Sub-module reg_word16: one DATA_W-bit register with clk, rst (async, active-high) and write enable, reset value 0. Instantiate it NREGS-1 times via generate.
- The scoreboard, bypass muxes and stall logic live in the top module.

## Test plan
- Reset and write:
  - Assert rst mid-cycle after loading R3=0x1234 → R3 and all outputs return to 0 immediately.
  - Write R5=0xBEEF, then read A=5 next cycle → ra_data=0xBEEF, ra_busy=0.
- R0 and bypass:
  - Write R0=0xFFFF → ra_addr=0 gives 0 forever, with no pending bit set.
  - Same-cycle bypass: wr_en=1, wr_addr=2, wr_data=0xA5A5, ra_addr=rb_addr=2 → both data outputs 0xA5A5 in that cycle.
- Reservation, stall and release:
  - Issue R4. Next cycle, issue with ra_addr=4 → ra_busy=1, stall=1.
  - In the following cycle, write R4=0x0042 → busy=0, stall=0 and ra_data=0x0042 in that same cycle; pending[4]=0 after the edge.
- Simultaneous set/clear:
  - With R6 pending: wr_en to R6 (0x0007) plus issue_en, issue_rd=6, with no operand hazards → stall=0, R6=0x0007, pending[6] stays 1.
  - A further issue of R6 → stall=1.
